// File: rtl/connect_pkg.sv
// Shared types and default widths for the AIDC/XHB mode connector.
// Payload widths match the CNN-engine channel bundles.
package connect_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } conn_state_t;

    localparam int AR_W_DEF      = 48;
    localparam int AW_W_DEF      = 48;
    localparam int W_W_DEF       = 37;
    localparam int R_W_DEF       = 38;
    localparam int B_W_DEF       = 6;
    localparam int MAX_OUTST_DEF = 8;

endpackage

// File: rtl/outst_counter.sv
// Saturating up/down outstanding-transaction counter.
// SIGNED adds one bit so the count may go negative (W data ahead of its AW).
module outst_counter #(
    parameter int MAX    = 8,
    parameter bit SIGNED = 1'b0,
    localparam int W     = $clog2(MAX + 1) + (SIGNED ? 1 : 0)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         empty,
    output logic         pos
);

    localparam logic [W-1:0] TOP    = W'(MAX);
    localparam logic [W-1:0] BOTTOM = SIGNED ? W'(-MAX) : '0;

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;
    logic         up;
    logic         down;
    logic         floor_hit;

    // Simultaneous inc and dec cancel out.
    assign up        = inc & ~dec;
    assign down      = dec & ~inc;
    assign full      = (count_reg == TOP);
    assign empty     = (count_reg == '0);
    assign floor_hit = (count_reg == BOTTOM);
    assign pos       = ~empty & ~(SIGNED & count_reg[W-1]);
    assign count     = count_reg;

    always_comb begin
        count_next = count_reg;
        if (up && !full) begin
            count_next = count_reg + 1'b1;
        end else if (down && !floor_hit) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // A completion with nothing outstanding means a protocol violation upstream.
    no_underflow: assert property (@(posedge clk) disable iff (rst) !(!SIGNED && down && empty));

endmodule

// File: rtl/axi_mode_connect.sv
// Routes engine AR/AW/W to the compression (c_) or memory (m_) path and
// returns R/B from it; mode changes wait until both paths are quiescent.
module axi_mode_connect
    import connect_pkg::*;
#(
    parameter int AR_W      = AR_W_DEF,
    parameter int AW_W      = AW_W_DEF,
    parameter int W_W       = W_W_DEF,
    parameter int R_W       = R_W_DEF,
    parameter int B_W       = B_W_DEF,
    parameter int MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable_i,
    output logic            mode_o,
    output logic            busy_o,
    input  logic            s_ar_valid,
    output logic            s_ar_ready,
    input  logic [AR_W-1:0] s_ar_payload,
    input  logic            s_aw_valid,
    output logic            s_aw_ready,
    input  logic [AW_W-1:0] s_aw_payload,
    input  logic            s_w_valid,
    output logic            s_w_ready,
    input  logic [W_W-1:0]  s_w_payload,
    input  logic            s_w_last,
    output logic            s_r_valid,
    input  logic            s_r_ready,
    output logic [R_W-1:0]  s_r_payload,
    output logic            s_r_last,
    output logic            s_b_valid,
    input  logic            s_b_ready,
    output logic [B_W-1:0]  s_b_payload,
    output logic            c_ar_valid,
    input  logic            c_ar_ready,
    output logic [AR_W-1:0] c_ar_payload,
    output logic            c_aw_valid,
    input  logic            c_aw_ready,
    output logic [AW_W-1:0] c_aw_payload,
    output logic            c_w_valid,
    input  logic            c_w_ready,
    output logic [W_W-1:0]  c_w_payload,
    output logic            c_w_last,
    input  logic            c_r_valid,
    output logic            c_r_ready,
    input  logic [R_W-1:0]  c_r_payload,
    input  logic            c_r_last,
    input  logic            c_b_valid,
    output logic            c_b_ready,
    input  logic [B_W-1:0]  c_b_payload,
    output logic            m_ar_valid,
    input  logic            m_ar_ready,
    output logic [AR_W-1:0] m_ar_payload,
    output logic            m_aw_valid,
    input  logic            m_aw_ready,
    output logic [AW_W-1:0] m_aw_payload,
    output logic            m_w_valid,
    input  logic            m_w_ready,
    output logic [W_W-1:0]  m_w_payload,
    output logic            m_w_last,
    input  logic            m_r_valid,
    output logic            m_r_ready,
    input  logic [R_W-1:0]  m_r_payload,
    input  logic            m_r_last,
    input  logic            m_b_valid,
    output logic            m_b_ready,
    input  logic [B_W-1:0]  m_b_payload
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    conn_state_t state_reg, state_next;
    logic        mode_reg, mode_next;

    logic [CNT_W-1:0] rd_cnt, wr_cnt;
    logic [CNT_W:0]   w_pend;
    logic rd_full, rd_empty, rd_pos;
    logic wr_full, wr_empty, wr_pos;
    logic w_full, w_empty, w_pos;
    logic ar_en, aw_en, w_en, rsp_en, sel_c;
    logic unused_sink;

    assign sel_c  = mode_reg;
    assign rsp_en = ~rst;
    assign ar_en  = ~rst & (state_reg == RUN) & ~rd_full;
    assign aw_en  = ~rst & (state_reg == RUN) & ~wr_full;
    // While draining, W may only finish bursts whose AW was already accepted.
    assign w_en   = ~rst & ((state_reg == RUN) | w_pos);

    assign c_ar_valid   = ar_en & sel_c & s_ar_valid;
    assign m_ar_valid   = ar_en & ~sel_c & s_ar_valid;
    assign c_ar_payload = s_ar_payload;
    assign m_ar_payload = s_ar_payload;
    assign s_ar_ready   = ar_en & (sel_c ? c_ar_ready : m_ar_ready);

    assign c_aw_valid   = aw_en & sel_c & s_aw_valid;
    assign m_aw_valid   = aw_en & ~sel_c & s_aw_valid;
    assign c_aw_payload = s_aw_payload;
    assign m_aw_payload = s_aw_payload;
    assign s_aw_ready   = aw_en & (sel_c ? c_aw_ready : m_aw_ready);

    assign c_w_valid    = w_en & sel_c & s_w_valid;
    assign m_w_valid    = w_en & ~sel_c & s_w_valid;
    assign c_w_payload  = s_w_payload;
    assign m_w_payload  = s_w_payload;
    assign c_w_last     = s_w_last;
    assign m_w_last     = s_w_last;
    assign s_w_ready    = w_en & (sel_c ? c_w_ready : m_w_ready);

    assign s_r_valid    = rsp_en & (sel_c ? c_r_valid : m_r_valid);
    assign s_r_payload  = sel_c ? c_r_payload : m_r_payload;
    assign s_r_last     = sel_c ? c_r_last : m_r_last;
    assign c_r_ready    = rsp_en & sel_c & s_r_ready;
    assign m_r_ready    = rsp_en & ~sel_c & s_r_ready;

    assign s_b_valid    = rsp_en & (sel_c ? c_b_valid : m_b_valid);
    assign s_b_payload  = sel_c ? c_b_payload : m_b_payload;
    assign c_b_ready    = rsp_en & sel_c & s_b_ready;
    assign m_b_ready    = rsp_en & ~sel_c & s_b_ready;

    outst_counter #(.MAX(MAX_OUTST), .SIGNED(1'b0)) u_rd_cnt (
        .clk(clk), .rst(rst),
        .inc(s_ar_valid & s_ar_ready),
        .dec(s_r_valid & s_r_ready & s_r_last),
        .count(rd_cnt), .full(rd_full), .empty(rd_empty), .pos(rd_pos)
    );

    outst_counter #(.MAX(MAX_OUTST), .SIGNED(1'b0)) u_wr_cnt (
        .clk(clk), .rst(rst),
        .inc(s_aw_valid & s_aw_ready),
        .dec(s_b_valid & s_b_ready),
        .count(wr_cnt), .full(wr_full), .empty(wr_empty), .pos(wr_pos)
    );

    outst_counter #(.MAX(MAX_OUTST), .SIGNED(1'b1)) u_w_pend (
        .clk(clk), .rst(rst),
        .inc(s_aw_valid & s_aw_ready),
        .dec(s_w_valid & s_w_ready & s_w_last),
        .count(w_pend), .full(w_full), .empty(w_empty), .pos(w_pos)
    );

    assign unused_sink = ^{rd_cnt, wr_cnt, w_pend, rd_pos, wr_pos, w_full};

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        case (state_reg)
            RUN: begin
                if (enable_i != mode_reg) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // enable_i is re-sampled at exit, so a bounced request lands back on the old mode.
                if (rd_empty && wr_empty && w_empty) begin
                    state_next = RUN;
                    mode_next  = enable_i;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            mode_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
        end
    end

    assign mode_o = mode_reg;
    assign busy_o = (state_reg == DRAIN);

endmodule
